ds_synapse: RTL and testbench
=============================

Name: ds_synapse

Overview:
- Upstream stage of the DS_LIF neuron. Converts presynaptic spike pulses into the 14-bit synaptic current that drives the neuron's syn_i.
- Holds a programmable weight per input and adds the weights of all inputs that spike in a cycle.
- The current register decays exponentially (shift-based) on a programmable prescaled tick.
- Output is registered and saturating, so it wires straight into DS_LIF syn_i.

Parameters:
- N_IN, 4, number of presynaptic inputs (1..16).
- W, 14, width of the current and weights; must match DS_LIF syn_i.
- AW, 2, weight address width; clog2(N_IN), minimum 1.

Ports:
- clk_in  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk_in.
- pre_spike  input  N_IN  presynaptic spikes; each high cycle on bit i is one spike on input i.
- w_we  input  1  weight write enable.
- w_addr  input  AW  weight index to write; ignored when >= N_IN.
- w_data  input  W  weight value, unsigned.
- tau_shift  input  4  decay shift; 0 disables decay.
- decay_div  input  16  decay tick period minus one.
- syn_o  output  W  synaptic current; connects to DS_LIF syn_i.
- sat_o  output  1  one-cycle pulse when this cycle's update clipped at full scale.

Behaviour:
- Reset (reset_n low at the rising edge):
  - syn_o = 0, sat_o = 0.
  - All weights = 0.
  - Prescaler count = 0.
  - Reset mid-operation discards all state on that edge; any pre_spike or w_we in that cycle is ignored.
- Weight file:
  - w_we=1 with w_addr<N_IN writes w_data on the edge.
  - The new weight is first used the following cycle. A spike on the same input in the write cycle uses the old weight.
  - A write with an out-of-range address is dropped.
- Prescaler:
  - cnt increments each cycle.
  - When cnt >= decay_div, tick=1 for that cycle and cnt clears to 0 on the edge.
  - decay_div=0 gives a tick every cycle.
  - Lowering decay_div below the current cnt produces a tick on the next cycle.
- Decay term, evaluated in the current cycle:
  - If tick and tau_shift != 0: d = syn_o >> tau_shift; if d == 0 and syn_o != 0, then d = 1, so the current always reaches 0.
  - Otherwise d = 0.
- Spike sum:
  - S = sum of weight[i] over all inputs with pre_spike[i]=1.
  - Computed at W+4 bits with no wrap.
  - All inputs spiking together in one cycle are all counted; there is no arbitration and no loss.
- Update:
  - next = (syn_o - d) + S.
  - If next > 2^W-1, syn_o <= 2^W-1 and sat_o <= 1; otherwise syn_o <= next and sat_o <= 0.
  - Decay is applied before the add, so a spike and a tick in the same cycle compose deterministically.
- Latency: a spike in cycle t is visible on syn_o in cycle t+1.
- No underflow is possible, since d <= syn_o.
- tau_shift and decay_div are quasi-static, but a change takes effect at the next evaluation.

Test Plan:
- Reset:
  - Stimulus: hold reset_n low 3 cycles with pre_spike=4'hF and w_we pulsing.
  - Required: syn_o=0 and sat_o=0 throughout; a later spike on input 0 adds 0, because the weights were cleared.
- Single spike, no decay:
  - Stimulus: weight[2]=100, tau_shift=0, pulse pre_spike[2] for 1 cycle.
  - Required: syn_o=100 one cycle later, then holds at 100 indefinitely.
- Decay:
  - Stimulus: syn_o=1024, tau_shift=1, decay_div=3.
  - Required: syn_o goes 512, 256, ... with one step every 4 cycles. At syn_o=1 the next tick gives 0 via the force-1 rule.
- Simultaneous spikes with saturation:
  - Stimulus: weights 0x1000, 0x1000, 0x1000, 0x1000; pulse all four inputs in one cycle.
  - Required: syn_o=0x3FFF and sat_o=1 for exactly one cycle.
- Write/spike collision:
  - Stimulus: weight[1]=10; in one cycle, write weight[1]=50 and pulse pre_spike[1]; pulse pre_spike[1] again the next cycle. tau_shift=0.
  - Required: syn_o goes 10, then 60.
- Tick plus spike in the same cycle:
  - Stimulus: syn_o=800, tau_shift=2, decay_div=0, weight[0]=40, pulse pre_spike[0].
  - Required: syn_o = 800 - 200 + 40 = 640.

Source files
------------

// File: rtl/ds_synapse.sv
// ds_synapse: presynaptic spike-to-current stage feeding the DS_LIF neuron.
// Each input owns a programmable weight; the weights of every input spiking
// in a cycle are summed into a current register. That register decays by a
// shift-based exponential step on a prescaled tick. The result is clipped at
// full scale, so syn_o can drive DS_LIF syn_i directly.
//
// Handshake: there is no valid/ready pair. Every input is sampled on every
// rising edge of clk_in. A spike in cycle t is reflected on syn_o in cycle t+1.
module ds_synapse #(
  parameter int N_IN = 4,
  parameter int W    = 14,
  parameter int AW   = 2
) (
  input  logic            clk_in,
  input  logic            reset_n,
  input  logic [N_IN-1:0] pre_spike,
  input  logic            w_we,
  input  logic [AW-1:0]   w_addr,
  input  logic [W-1:0]    w_data,
  input  logic [3:0]      tau_shift,
  input  logic [15:0]     decay_div,
  output logic [W-1:0]    syn_o,
  output logic            sat_o
);

  // The spike sum carries 4 guard bits, enough for up to 16 full-scale
  // weights. The update carries one more bit, so that the current plus the
  // sum can never wrap before the clip.
  localparam int SW = W + 4;
  localparam int NW = W + 5;
  localparam logic [NW-1:0] FULL_EXT = {{5{1'b0}}, {W{1'b1}}};

  logic [W-1:0]  weight_q [N_IN];
  logic [W-1:0]  weight_d [N_IN];
  logic [15:0]   cnt_q, cnt_d;
  logic [W-1:0]  syn_q, syn_d;
  logic          sat_q, sat_d;

  logic          tick;
  logic [W-1:0]  shifted;
  logic [W-1:0]  decay;
  logic [W-1:0]  decayed;
  logic [SW-1:0] spike_sum;
  logic [NW-1:0] next_val;

  // Weight file: a matching in-range address overwrites one entry. An address
  // at or above N_IN matches no entry, so that write is dropped.
  always_comb begin
    weight_d = weight_q;
    for (int i = 0; i < N_IN; i++) begin
      if (w_we && ({1'b0, w_addr} == (AW + 1)'(i))) begin
        weight_d[i] = w_data;
      end
    end
  end

  // Prescaler: the tick fires when the count reaches or passes decay_div. The
  // comparison is >= rather than ==, so that lowering decay_div below the
  // running count still ticks on the next cycle.
  always_comb begin
    tick  = (cnt_q >= decay_div);
    cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
  end

  // Decay term: the step is shift-based. A step that rounds to zero is forced
  // to 1 while any current remains, so the register always reaches 0.
  always_comb begin
    shifted = syn_q >> tau_shift;
    decay   = '0;
    if (tick && (tau_shift != 4'd0)) begin
      decay = shifted;
      if ((shifted == '0) && (syn_q != '0)) begin
        decay = W'(1);
      end
    end
  end

  // Spike sum: every spiking input contributes, and there is no arbitration.
  // The weights used are the registered ones. A write in the same cycle
  // therefore takes effect only from the next cycle on.
  always_comb begin
    spike_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (pre_spike[i]) begin
        spike_sum = spike_sum + {4'b0000, weight_q[i]};
      end
    end
  end

  // Update: the decay is applied before the add. The subtraction cannot
  // underflow, because decay <= syn_q. The result is clipped at full scale.
  always_comb begin
    decayed  = syn_q - decay;
    next_val = {5'b00000, decayed} + {1'b0, spike_sum};
    syn_d    = next_val[W-1:0];
    sat_d    = 1'b0;
    if (next_val > FULL_EXT) begin
      syn_d = '1;
      sat_d = 1'b1;
    end
  end

  // State registers. Reset discards all state and ignores any spike or write
  // presented in the same cycle.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      for (int i = 0; i < N_IN; i++) begin
        weight_q[i] <= '0;
      end
      cnt_q <= '0;
      syn_q <= '0;
      sat_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        weight_q[i] <= weight_d[i];
      end
      cnt_q <= cnt_d;
      syn_q <= syn_d;
      sat_q <= sat_d;
    end
  end

  assign syn_o = syn_q;
  assign sat_o = sat_q;

endmodule

// File: tb/tb_ds_synapse.sv
// tb_ds_synapse: directed bench for ds_synapse. The driver pushes a
// hand-computed {sat, syn} expectation for each checked cycle. A monitor pops
// that expectation and compares it after the following rising edge.
module tb_ds_synapse;

  localparam int W = 14;

  logic          clk_in;
  logic          reset_n;
  logic [3:0]    pre_spike;
  logic          w_we;
  logic [1:0]    w_addr;
  logic [W-1:0]  w_data;
  logic [3:0]    tau_shift;
  logic [15:0]   decay_div;
  logic [W-1:0]  syn_o;
  logic          sat_o;

  logic [W:0]    exp_q[$];
  string         name_q[$];
  int            checks   = 0;
  int            failures = 0;

  ds_synapse #(.N_IN(4), .W(W), .AW(2)) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .pre_spike (pre_spike),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .tau_shift (tau_shift),
    .decay_div (decay_div),
    .syn_o     (syn_o),
    .sat_o     (sat_o)
  );

  // clock / reset block
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // monitor: compares after each rising edge, whenever an expectation is pending
  always begin
    logic [W:0] e;
    string      nm;
    @(posedge clk_in);
    #2;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if ({sat_o, syn_o} !== e) begin
        failures++;
        $display("FAIL %s: got syn_o=%0d sat_o=%0b, expected syn_o=%0d sat_o=%0b",
                 nm, syn_o, sat_o, e[W-1:0], e[W]);
      end
    end
  end

  // driver: applies one cycle of inputs and, if chk is set, queues the
  // expected outputs after this cycle's rising edge
  task automatic cyc(input logic [3:0] spk, input logic we, input logic [1:0] addr,
                     input logic [W-1:0] data, input logic chk,
                     input logic [W-1:0] es, input logic esat, input string nm);
    pre_spike = spk;
    w_we      = we;
    w_addr    = addr;
    w_data    = data;
    if (chk) begin
      exp_q.push_back({esat, es});
      name_q.push_back(nm);
    end
    @(negedge clk_in);
  endtask

  task automatic rst_cycle(input string nm);
    reset_n = 1'b0;
    cyc(4'h0, 1'b0, 2'd0, '0, 1'b1, '0, 1'b0, nm);
    reset_n = 1'b1;
  endtask

  int dec_tab[11] = '{512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0};

  initial begin
    reset_n   = 1'b0;
    pre_spike = '0;
    w_we      = 1'b0;
    w_addr    = '0;
    w_data    = '0;
    tau_shift = 4'd0;
    decay_div = 16'd0;
    @(negedge clk_in);

    // reset held 3 cycles with all spikes and pulsing writes
    cyc(4'hF, 1'b1, 2'd0, 14'd500, 1'b1, 14'd0, 1'b0, "reset_hold0");
    cyc(4'hF, 1'b0, 2'd1, 14'd500, 1'b1, 14'd0, 1'b0, "reset_hold1");
    cyc(4'hF, 1'b1, 2'd2, 14'd500, 1'b1, 14'd0, 1'b0, "reset_hold2");
    reset_n = 1'b1;
    cyc(4'h1, 1'b0, 2'd0, '0, 1'b1, 14'd0, 1'b0, "reset_w0_cleared");
    cyc(4'hF, 1'b0, 2'd0, '0, 1'b1, 14'd0, 1'b0, "reset_all_cleared");

    // single spike, no decay
    cyc(4'h0, 1'b1, 2'd2, 14'd100, 1'b1, 14'd0, 1'b0, "single_write");
    cyc(4'h4, 1'b0, 2'd0, '0, 1'b1, 14'd100, 1'b0, "single_spike");
    for (int i = 0; i < 5; i++) cyc(4'h0, 1'b0, 2'd0, '0, 1'b1, 14'd100, 1'b0, "single_hold");

    // decay: 1024 halves every 4 cycles, with the final 1 -> 0 by the force-1 step
    rst_cycle("decay_reset");
    tau_shift = 4'd1;
    decay_div = 16'd3;
    cyc(4'h0, 1'b1, 2'd0, 14'd1024, 1'b1, 14'd0, 1'b0, "decay_write");
    cyc(4'h1, 1'b0, 2'd0, '0, 1'b1, 14'd1024, 1'b0, "decay_load");
    cyc(4'h0, 1'b0, 2'd0, '0, 1'b1, 14'd1024, 1'b0, "decay_pre");
    for (int k = 0; k < 11; k++) begin
      cyc(4'h0, 1'b0, 2'd0, '0, 1'b1, W'(dec_tab[k]), 1'b0, "decay_step");
      for (int j = 0; j < 3; j++) cyc(4'h0, 1'b0, 2'd0, '0, 1'b1, W'(dec_tab[k]), 1'b0, "decay_flat");
    end
    tau_shift = 4'd0;

    // simultaneous spikes saturate; sat_o pulses for exactly one cycle
    for (int a = 0; a < 4; a++) cyc(4'h0, 1'b1, 2'(a), 14'h1000, 1'b1, 14'd0, 1'b0, "sat_write");
    cyc(4'hF, 1'b0, 2'd0, '0, 1'b1, 14'h3FFF, 1'b1, "sat_clip");
    cyc(4'h0, 1'b0, 2'd0, '0, 1'b1, 14'h3FFF, 1'b0, "sat_pulse_end");
    cyc(4'h0, 1'b0, 2'd0, '0, 1'b1, 14'h3FFF, 1'b0, "sat_hold");

    // write/spike collision: the spike in the write cycle uses the old weight
    rst_cycle("coll_reset");
    cyc(4'h0, 1'b1, 2'd1, 14'd10, 1'b1, 14'd0, 1'b0, "coll_write_old");
    cyc(4'h2, 1'b1, 2'd1, 14'd50, 1'b1, 14'd10, 1'b0, "coll_old_weight");
    cyc(4'h2, 1'b0, 2'd0, '0, 1'b1, 14'd60, 1'b0, "coll_new_weight");

    // tick and spike in the same cycle: 800 - 200 + 40
    rst_cycle("combo_reset");
    cyc(4'h0, 1'b1, 2'd0, 14'd800, 1'b1, 14'd0, 1'b0, "combo_write800");
    cyc(4'h1, 1'b0, 2'd0, '0, 1'b1, 14'd800, 1'b0, "combo_load");
    cyc(4'h0, 1'b1, 2'd0, 14'd40, 1'b1, 14'd800, 1'b0, "combo_write40");
    tau_shift = 4'd2;
    decay_div = 16'd0;
    cyc(4'h1, 1'b0, 2'd0, '0, 1'b1, 14'd640, 1'b0, "combo_tick_spike");
    tau_shift = 4'd0;
    cyc(4'h0, 1'b0, 2'd0, '0, 1'b1, 14'd640, 1'b0, "combo_hold");

    // bounded drain of any pending expectations
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk_in);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
